aes_state_scanner: RTL and testbench

Downstream display stage for the AES round/state output. Captures a 128-bit AES state, then steps through its 16 bytes one at a time. Each byte is converted to three BCD digits with a sequential shift-add-3 (double-dabble) converter, and the digits are held for a programmable dwell time. The BCD outputs feed the existing BCD-to-seven-segment drivers, so the whole state can be read from three digits instead of only the least significant byte.

---
 rtl/aes_state_scanner.sv | 128 ++++++++++++
 tb/tb_aes_state_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_state_scanner.sv
// Steps through the 16 bytes of a captured AES state and converts each byte to
// three BCD digits with a sequential double-dabble converter. Each byte's digits
// are held for DWELL_CYCLES clocks.
module aes_state_scanner #(
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [0:127] state_in,
  input  logic         hold,
  output logic [3:0]   byte_idx,
  output logic [3:0]   hunds,
  output logic [3:0]   tens,
  output logic [3:0]   units,
  output logic         digits_valid,
  output logic         busy,
  output logic         wrap
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  localparam logic [25:0] DWELL_LOAD = 26'(DWELL_CYCLES - 1);

  state_t       state, nextState;
  logic [0:127] shadow;
  logic [19:0]  scratch;       // {hundreds, tens, units, binary}
  logic [19:0]  scratchNext;
  logic [3:0]   bitCnt;
  logic [25:0]  dwellCnt;
  logic [3:0]   nextIdx;
  logic [7:0]   nextByte;
  logic         convDone;
  logic         dwellDone;

  assign nextIdx   = byte_idx + 4'd1;
  assign nextByte  = shadow[{nextIdx, 3'b000} +: 8];
  assign convDone  = (bitCnt == 4'd8);
  assign dwellDone = (dwellCnt == 26'd0) && !hold;

  // One double-dabble step: correct every BCD nibble that would overflow, then shift.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    scratchNext = scratch;
    if (scratchNext[19:16] >= 4'd5) scratchNext[19:16] = scratchNext[19:16] + 4'd3;
    if (scratchNext[15:12] >= 4'd5) scratchNext[15:12] = scratchNext[15:12] + 4'd3;
    if (scratchNext[11:8]  >= 4'd5) scratchNext[11:8]  = scratchNext[11:8]  + 4'd3;
    scratchNext = {scratchNext[18:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (load) begin
      nextState = CONVERT;
    end else begin
      unique case (state)
        IDLE:    nextState = IDLE;
        CONVERT: if (convDone) nextState = SHOW;
        SHOW:    if (dwellDone) nextState = CONVERT;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == CONVERT);
  end

  // load wins over both an in-flight conversion and an expiring dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      scratch      <= '0;
      bitCnt       <= '0;
      dwellCnt     <= '0;
      byte_idx     <= '0;
      hunds        <= '0;
      tens         <= '0;
      units        <= '0;
      digits_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        shadow       <= state_in;
        scratch      <= {12'd0, state_in[0:7]};
        bitCnt       <= '0;
        byte_idx     <= '0;
        digits_valid <= 1'b0;
      end else begin
        unique case (state)
          CONVERT: begin
            if (convDone) begin
              hunds        <= scratch[19:16];
              tens         <= scratch[15:12];
              units        <= scratch[11:8];
              digits_valid <= 1'b1;
              dwellCnt     <= DWELL_LOAD;
            end else begin
              scratch <= scratchNext;
              bitCnt  <= bitCnt + 4'd1;
            end
          end
          SHOW: begin
            if (dwellDone) begin
              byte_idx <= nextIdx;
              wrap     <= (byte_idx == 4'd15);
              scratch  <= {12'd0, nextByte};
              bitCnt   <= '0;
            end else if (!hold) begin
              dwellCnt <= dwellCnt - 26'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_state_scanner.sv
// Scoreboard bench for aes_state_scanner: expected digit commits are queued as
// stimulus is driven and compared (value and edge) when the DUT commits.
module tb_aes_state_scanner;

  localparam int DWELL = 4;
  localparam int PERIOD = DWELL + 9;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    int         edgeNum;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [0:127] stateIn = '0;
  logic         hold = 1'b0;
  logic [3:0]   byteIdx, hunds, tens, units;
  logic         digitsValid, busy, wrap;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   loadEdge = 0;
  logic prevBusy = 1'b0;
  exp_t expQ[$];
  int   wrapEdgeQ[$];
  int   wrapIdxQ[$];

  localparam logic [0:127] VEC_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] VEC_B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_state_scanner #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .load(load), .state_in(stateIn), .hold(hold),
    .byte_idx(byteIdx), .hunds(hunds), .tens(tens), .units(units),
    .digits_valid(digitsValid), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Commit monitor: busy falling with valid digits marks a commit edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (wrap) begin
      wrapEdgeQ.push_back(cyc);
      wrapIdxQ.push_back(int'(byteIdx));
    end
    if (prevBusy && !busy && digitsValid && expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if ({byteIdx, hunds, tens, units} !== {e.idx, e.h, e.t, e.u} || cyc != e.edgeNum) begin
        bad++;
        $display("FAIL commit: got edge=%0d idx=%0d digits=%0d/%0d/%0d, expected edge=%0d idx=%0d digits=%0d/%0d/%0d",
                 cyc, byteIdx, hunds, tens, units, e.edgeNum, e.idx, e.h, e.t, e.u);
      end
    end
    prevBusy = busy;
  end

  task automatic pushByte(input logic [0:127] vec, input int k, input int edgeNum);
    exp_t e;
    int   b;
    b = int'(vec[8*k +: 8]);
    e.idx = 4'(k);
    e.h = 4'(b / 100);
    e.t = 4'((b / 10) % 10);
    e.u = 4'(b % 10);
    e.edgeNum = edgeNum;
    expQ.push_back(e);
  endtask

  task automatic doLoad(input logic [0:127] vec);
    stateIn = vec;
    load = 1'b1;
    loadEdge = cyc + 1;
    @(negedge clk);
    load = 1'b0;
    stateIn = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitEdge(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL %s drain: %0d expected commits never seen, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({byteIdx, hunds, tens, units, digitsValid, busy, wrap} !== 19'd0) begin
      bad++;
      $display("FAIL reset_held: got outputs=%h, expected 0",
               {byteIdx, hunds, tens, units, digitsValid, busy, wrap});
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({byteIdx, hunds, tens, units, digitsValid, busy, wrap} !== 19'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got outputs=%h, expected 0", i,
                 {byteIdx, hunds, tens, units, digitsValid, busy, wrap});
      end
    end
  endtask

  task automatic test_scan_wrap;
    int e0;
    wrapEdgeQ.delete();
    wrapIdxQ.delete();
    doLoad(VEC_A);
    e0 = loadEdge + 9;
    for (int k = 0; k <= 16; k++) pushByte(VEC_A, k % 16, e0 + PERIOD * k);
    // byte_idx leads the digits: just after entering CONVERT for byte 2.
    waitEdge(e0 + 2 * PERIOD - 9);
    total++;
    if (byteIdx !== 4'd2 || busy !== 1'b1 || {hunds, tens, units} !== 12'h017) begin
      bad++;
      $display("FAIL idx_lead: got idx=%0d busy=%b digits=%0d/%0d/%0d, expected idx=2 busy=1 digits=0/1/7",
               byteIdx, busy, hunds, tens, units);
    end
    waitDrain(400, "scan");
    total++;
    if (wrapEdgeQ.size() != 1) begin
      bad++;
      $display("FAIL wrap_count: got %0d wrap cycles, expected 1", wrapEdgeQ.size());
    end else if (wrapEdgeQ[0] != e0 + 16 * PERIOD - 9 || wrapIdxQ[0] != 0) begin
      bad++;
      $display("FAIL wrap_timing: got edge=%0d idx=%0d, expected edge=%0d idx=0",
               wrapEdgeQ[0], wrapIdxQ[0], e0 + 16 * PERIOD - 9);
    end
  endtask

  task automatic test_hold;
    int e0, e3;
    doLoad(VEC_A);
    e0 = loadEdge + 9;
    e3 = e0 + 3 * PERIOD;
    for (int k = 0; k <= 3; k++) pushByte(VEC_A, k, e0 + PERIOD * k);
    pushByte(VEC_A, 4, e0 + 4 * PERIOD + 10);
    pushByte(VEC_A, 5, e0 + 5 * PERIOD + 10);
    waitEdge(e3 + 1);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (byteIdx !== 4'd3 || {hunds, tens, units} !== 12'h051 || digitsValid !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL hold cycle %0d: got idx=%0d digits=%0d/%0d/%0d valid=%b busy=%b, expected idx=3 digits=0/5/1 valid=1 busy=0",
                 i, byteIdx, hunds, tens, units, digitsValid, busy);
      end
    end
    hold = 1'b0;
    waitDrain(200, "hold");
  endtask

  task automatic test_load_mid_convert;
    logic prevB;
    int   n = 0;
    prevB = busy;
    @(negedge clk);
    while (!(busy && !prevB) && n < 100) begin
      prevB = busy;
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL find_convert: got no CONVERT entry within 100 cycles, expected one");
    end
    repeat (3) @(negedge clk);
    doLoad(VEC_B);
    total++;
    if (digitsValid !== 1'b0 || busy !== 1'b1 || byteIdx !== 4'd0) begin
      bad++;
      $display("FAIL reload: got valid=%b busy=%b idx=%0d, expected valid=0 busy=1 idx=0",
               digitsValid, busy, byteIdx);
    end
    pushByte(VEC_B, 0, loadEdge + 9);
    pushByte(VEC_B, 1, loadEdge + 9 + PERIOD);
    waitDrain(100, "reload");
  endtask

  task automatic test_async_reset;
    int n = 0;
    while (!(digitsValid && !busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({byteIdx, hunds, tens, units, digitsValid, busy, wrap} !== 19'd0) begin
      bad++;
      $display("FAIL async_reset: got outputs=%h before the next edge, expected 0",
               {byteIdx, hunds, tens, units, digitsValid, busy, wrap});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if ({byteIdx, hunds, tens, units, digitsValid, busy, wrap} !== 19'd0) begin
        bad++;
        $display("FAIL post_reset_idle cycle %0d: got outputs=%h, expected 0", i,
                 {byteIdx, hunds, tens, units, digitsValid, busy, wrap});
      end
    end
    doLoad(VEC_B);
    pushByte(VEC_B, 0, loadEdge + 9);
    waitDrain(40, "restart");
  endtask

  initial begin
    test_reset();
    test_scan_wrap();
    test_hold();
    test_load_mid_convert();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
